pipe_stall_ctrl: RTL and testbench

Central hazard and stall controller that drives the freeze and flush inputs of every pipeline register: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It detects three conditions: load-use and RAW data hazards, taken-branch control hazards, and multicycle data-memory accesses. Memory accesses are sequenced through a handshake FSM with a timeout. Two saturating counters record stall cycles for performance monitoring.

---
 rtl/pipe_stall_ctrl_if.sv | 22 ++
 rtl/pipe_stall_ctrl.sv | 56 +++++
 tb/tb_pipe_stall_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard inputs and freeze/flush/monitor outputs between the pipeline and its stall controller
//   master: pipeline side, drives register ids, write/load enables, branch and memory handshake
//   slave:  controller side, drives freezes, flushes, mem_start, mem_err and stall counters
interface pipe_stall_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en, br_taken, mem_req, mem_ready;
  logic pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze, mem_wb_freeze;
  logic if_id_flush, id_ex_flush, mem_start, mem_err;
  logic [CNT_W-1:0] data_stall_cnt, mem_stall_cnt;
  modport master (
    output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           fwd_en, br_taken, mem_req, mem_ready,
    input  pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze, mem_wb_freeze,
           if_id_flush, id_ex_flush, mem_start, mem_err, data_stall_cnt, mem_stall_cnt
  );
  modport slave (
    input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           fwd_en, br_taken, mem_req, mem_ready,
    output pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze, mem_wb_freeze,
           if_id_flush, id_ex_flush, mem_start, mem_err, data_stall_cnt, mem_stall_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/stall controller driving freeze and flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   clk, rst (async, active-high); bus: pipe_stall_ctrl_if.slave carrying hazard inputs,
//   memory handshake, freeze/flush outputs, sticky timeout flag and saturating stall counters
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [CNT_W-1:0] dcnt, mcnt;
  logic err, hit, mem_stall, s_exe, s_mem, raw, hz, brf;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tmo <= '0;
      err <= 1'b0;
      dcnt <= '0;
      mcnt <= '0;
    end else begin
      state <= state_n;
      tmo <= tmo_n;
      err <= err | hit;
      dcnt <= dcnt + CNT_W'(hz && !(&dcnt));
      mcnt <= mcnt + CNT_W'(mem_stall && !(&mcnt));
    end
  always_comb begin
    hit = state == MEM_WAIT && !bus.mem_ready && tmo == TW'(MEM_TIMEOUT - 1);
    // the timeout cycle itself releases the pipeline
    mem_stall = !rst && (state == IDLE ? bus.mem_req : !bus.mem_ready && !hit);
    state_n = state == IDLE ? (bus.mem_req ? MEM_WAIT : IDLE) : (bus.mem_ready || hit ? IDLE : MEM_WAIT);
    tmo_n = state == MEM_WAIT && !bus.mem_ready && !hit ? tmo + 1'b1 : '0;
    s_exe = bus.exe_dest != 5'd0 && (bus.exe_dest == bus.id_src1 || (bus.id_two_src && bus.exe_dest == bus.id_src2));
    s_mem = bus.mem_dest != 5'd0 && (bus.mem_dest == bus.id_src1 || (bus.id_two_src && bus.mem_dest == bus.id_src2));
    raw = bus.fwd_en ? s_exe && bus.exe_mem_r_en : (s_exe && bus.exe_wb_en) || (s_mem && bus.mem_wb_en);
    // a taken branch discards the ID instruction, so its hazard never stalls
    brf = !rst && !mem_stall && bus.br_taken;
    hz = !rst && !mem_stall && !bus.br_taken && raw;
    bus.pc_freeze = mem_stall || hz;
    bus.if_id_freeze = mem_stall || hz;
    bus.id_ex_freeze = mem_stall;
    bus.ex_mem_freeze = mem_stall;
    bus.mem_wb_freeze = mem_stall;
    bus.if_id_flush = brf;
    bus.id_ex_flush = brf || hz;
    bus.mem_start = !rst && state == IDLE && bus.mem_req;
  end
  assign bus.mem_err = err;
  assign bus.data_stall_cnt = dcnt;
  assign bus.mem_stall_cnt = mcnt;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed test of pipe_stall_ctrl against a behavioural model plus literal checkpoints
module tb_pipe_stall_ctrl;
  localparam int TO = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0;
  logic rst = 1;
  pipe_stall_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  bit busy;
  int waited, m_err, m_d, m_m;
  int n_cmp, n_bad, n_start;
  function automatic bit reads(input logic [4:0] r);
    return r != 0 && (r == bus.id_src1 || (bus.id_two_src && r == bus.id_src2));
  endfunction
  function automatic bit e_ms();
    if (rst) return 0;
    if (!busy) return bus.mem_req;
    return !bus.mem_ready && waited < TO - 1;
  endfunction
  function automatic bit e_raw();
    if (bus.fwd_en) return bus.exe_mem_r_en && reads(bus.exe_dest);
    return (bus.exe_wb_en && reads(bus.exe_dest)) || (bus.mem_wb_en && reads(bus.mem_dest));
  endfunction
  function automatic bit e_hz();
    return !rst && !e_ms() && !bus.br_taken && e_raw();
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(posedge clk or posedge rst)
    if (rst) begin
      busy = 0; waited = 0; m_err = 0; m_d = 0; m_m = 0;
    end else begin
      if (e_hz() && m_d < CMAX) m_d++;
      if (e_ms() && m_m < CMAX) m_m++;
      if (!busy) begin
        if (bus.mem_req) begin busy = 1; waited = 0; end
      end else if (bus.mem_ready) busy = 0;
      else if (waited == TO - 1) begin m_err = 1; busy = 0; end
      else waited++;
    end
  always @(negedge clk) begin
    bit ms, hz, br;
    ms = e_ms();
    hz = e_hz();
    br = !rst && !ms && bus.br_taken;
    if (bus.mem_start) n_start++;
    chk("pc_freeze", bus.pc_freeze, ms | hz);
    chk("if_id_freeze", bus.if_id_freeze, ms | hz);
    chk("id_ex_freeze", bus.id_ex_freeze, ms);
    chk("ex_mem_freeze", bus.ex_mem_freeze, ms);
    chk("mem_wb_freeze", bus.mem_wb_freeze, ms);
    chk("if_id_flush", bus.if_id_flush, br);
    chk("id_ex_flush", bus.id_ex_flush, br | hz);
    chk("mem_start", bus.mem_start, !rst && !busy && bus.mem_req);
    chk("mem_err", bus.mem_err, m_err);
    chk("data_stall_cnt", bus.data_stall_cnt, m_d);
    chk("mem_stall_cnt", bus.mem_stall_cnt, m_m);
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    bus.id_src1 = 0; bus.id_src2 = 0; bus.id_two_src = 0; bus.exe_dest = 0; bus.exe_wb_en = 0;
    bus.exe_mem_r_en = 0; bus.mem_dest = 0; bus.mem_wb_en = 0; bus.fwd_en = 1; bus.br_taken = 0;
    bus.mem_req = 0; bus.mem_ready = 0;
  endtask
  initial begin
    int s0;
    clr();
    cyc(2);
    chk("lit_reset_mem_start", bus.mem_start, 0);
    rst = 0;
    chk("lit_reset_cnt", bus.data_stall_cnt, 0);
    bus.id_src1 = 3; bus.id_src2 = 4; bus.id_two_src = 1; bus.exe_dest = 5; bus.exe_wb_en = 1;
    cyc(1);
    chk("lit_nohz_cnt", bus.data_stall_cnt, 0);
    clr();
    bus.exe_mem_r_en = 1; bus.exe_dest = 7; bus.id_src1 = 7;
    #1 chk("lit_loaduse_pc_freeze", bus.pc_freeze, 1);
    cyc(1);
    chk("lit_loaduse_cnt", bus.data_stall_cnt, 1);
    bus.id_src1 = 0; bus.exe_dest = 0;
    #1 chk("lit_r0_pc_freeze", bus.pc_freeze, 0);
    cyc(1);
    clr();
    bus.fwd_en = 0; bus.mem_dest = 9; bus.mem_wb_en = 1; bus.id_src1 = 3; bus.id_src2 = 9;
    cyc(1);
    bus.id_two_src = 1;
    cyc(1);
    chk("lit_nofwd_cnt", bus.data_stall_cnt, 2);
    clr();
    s0 = n_start;
    bus.mem_req = 1; bus.br_taken = 1; bus.exe_mem_r_en = 1; bus.exe_dest = 7; bus.id_src1 = 7;
    cyc(4);
    bus.mem_ready = 1;
    #1 chk("lit_ready_freeze", bus.id_ex_freeze, 0);
    cyc(1);
    clr();
    bus.mem_ready = 1;
    cyc(1);
    bus.mem_ready = 0;
    chk("lit_mem_cnt", bus.mem_stall_cnt, 4);
    chk("lit_mem_start_once", n_start - s0, 1);
    bus.mem_req = 1;
    cyc(TO + 1);
    bus.mem_req = 0;
    chk("lit_tmo_err", bus.mem_err, 1);
    chk("lit_tmo_cnt", bus.mem_stall_cnt, 12);
    cyc(1);
    bus.mem_req = 1;
    cyc(TO + 1);
    bus.mem_req = 0;
    cyc(1);
    chk("lit_sat_cnt", bus.mem_stall_cnt, CMAX);
    bus.exe_mem_r_en = 1; bus.exe_dest = 7; bus.id_src1 = 7; bus.br_taken = 1;
    #1 chk("lit_br_pc_freeze", bus.pc_freeze, 0);
    cyc(1);
    chk("lit_br_cnt", bus.data_stall_cnt, 2);
    clr();
    bus.mem_req = 1;
    cyc(2);
    rst = 1;
    cyc(1);
    chk("lit_abort_err", bus.mem_err, 0);
    rst = 0; bus.mem_req = 0;
    cyc(1);
    bus.mem_req = 1;
    cyc(1);
    bus.mem_ready = 1;
    cyc(1);
    clr();
    cyc(2);
    chk("lit_end_mem_cnt", bus.mem_stall_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
